// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle R-type issue controller feeding the ALU.
// Flow per instruction: IDLE -> DECODE -> EXEC -> WB -> IDLE (one op per 4 cycles).
// Optional feature macro: ALU_ILLEGAL_TRAP_EN
//   defined   : an illegal word parks the controller in TRAP with a sticky illegal flag
//   undefined : an illegal word is dropped as a NOP with a one-cycle illegal pulse
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [5:0]        alu_funct,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              illegal
);

  localparam logic [5:0] FN_ADD = 6'b001001;
  localparam logic [5:0] FN_SUB = 6'b001010;
  localparam logic [5:0] FN_OR  = 6'b010010;
  localparam logic [5:0] FN_SRL = 6'b100010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  // Only R-type words with one of the four supported functs may reach the ALU.
  function automatic logic is_legal(input logic [31:0] word);
    logic ok;
    ok = 1'b0;
    if (word[31:26] == 6'b000000) begin
      case (word[5:0])
        FN_ADD, FN_SUB, FN_OR, FN_SRL: ok = 1'b1;
        default:                       ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [31:0]         instr_r;
  logic                accept_s;
  logic                legal_s;
  logic [REG_AW-1:0]   rd_s;
  logic                instr_ready_s;
  logic [DATA_W-1:0]   alu_src1_r;
  logic [DATA_W-1:0]   alu_src2_r;
  logic [5:0]          alu_funct_r;
  logic [4:0]          alu_shamt_r;
  logic                wb_en_r;
  logic [REG_AW-1:0]   wb_addr_r;
  logic [DATA_W-1:0]   wb_data_r;
  logic                zero_flag_r;
  logic                illegal_r;

  assign accept_s = instr_valid && instr_ready_s;
  assign legal_s  = is_legal(instr_r);
  assign rd_s     = REG_AW'(instr_r[15:11]);

  // Register-file addresses come straight from the latched word so they are valid in DECODE.
  assign rs_addr     = REG_AW'(instr_r[25:21]);
  assign rt_addr     = REG_AW'(instr_r[20:16]);
  assign instr_ready = instr_ready_s;
  assign alu_src1    = alu_src1_r;
  assign alu_src2    = alu_src2_r;
  assign alu_funct   = alu_funct_r;
  assign alu_shamt   = alu_shamt_r;
  assign wb_en       = wb_en_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign zero_flag   = zero_flag_r;
  assign illegal     = illegal_r;

  // State register; a reset in any state aborts the operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic for the issue sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (legal_s) begin
          state_s = ST_EXEC;
        end else begin
`ifdef ALU_ILLEGAL_TRAP_EN
          state_s = ST_TRAP;
`else
          state_s = ST_IDLE;
`endif
        end
      end
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_IDLE;
`ifdef ALU_ILLEGAL_TRAP_EN
      ST_TRAP: state_s = ST_TRAP;
`else
      ST_TRAP: state_s = ST_IDLE;
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake output: the controller only takes a new word while idle.
  always_comb begin
    instr_ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      instr_ready_s = 1'b1;
    end else begin
      instr_ready_s = 1'b0;
    end
  end

  // Datapath registers: instruction latch, ALU operand drive, result capture and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r     <= 32'h0000_0000;
      alu_src1_r  <= {DATA_W{1'b0}};
      alu_src2_r  <= {DATA_W{1'b0}};
      alu_funct_r <= 6'b000000;
      alu_shamt_r <= 5'b00000;
      wb_en_r     <= 1'b0;
      wb_addr_r   <= {REG_AW{1'b0}};
      wb_data_r   <= {DATA_W{1'b0}};
      zero_flag_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      wb_en_r <= 1'b0;
      // Legality is registered with the word so the flag is visible during DECODE itself.
      if (accept_s) begin
        instr_r   <= instr;
        illegal_r <= !is_legal(instr);
      end else begin
`ifdef ALU_ILLEGAL_TRAP_EN
        illegal_r <= illegal_r;
`else
        illegal_r <= 1'b0;
`endif
      end
      // Operands are loaded at the end of DECODE and held stable through EXEC and beyond.
      if ((state_r == ST_DECODE) && legal_s) begin
        alu_src1_r  <= rs_data;
        alu_src2_r  <= rt_data;
        alu_funct_r <= instr_r[5:0];
        alu_shamt_r <= instr_r[10:6];
      end
      // The ALU answer is sampled at the end of EXEC; $0 is never written back.
      if (state_r == ST_EXEC) begin
        zero_flag_r <= alu_zero;
        if (rd_s != {REG_AW{1'b0}}) begin
          wb_en_r   <= 1'b1;
          wb_addr_r <= rd_s;
          wb_data_r <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed instructions, an ALU/register-file environment,
// a latency/outcome model checked every cycle, and literal expectations per scenario.
// Honours ALU_ILLEGAL_TRAP_EN the same way the design does.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_src1, alu_src2;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        zero_flag;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .zero_flag(zero_flag), .illegal(illegal)
  );

  // Environment: register file (bench-written only) and a behavioural ALU.
  logic [31:0] regs [0:31];
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  function automatic logic [31:0] alu_op(input logic [5:0] fn, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (fn)
      6'b001001: return a + b;
      6'b001010: return a - b;
      6'b010010: return a | b;
      6'b100010: return a >> sh;
      default:   return 32'h0000_0000;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_op(alu_funct, alu_src1, alu_src2, alu_shamt);
    alu_zero   = (alu_result == 32'h0000_0000);
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;   // index of the most recent rising edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: outcome and timing of each accepted word ----------------
  // A word accepted at edge N is in DECODE when sampled at cyc N, EXEC at N+1, WB at N+2.
  bit          checking   = 1'b0;
  int          ready_from = 0;
  int          trap_from  = -1;
  int          ex_cyc     = -1;
  int          wb_cyc     = -1;
  int          ill_cyc    = -1;
  int          zero_at    = -1;
  logic        zero_m     = 1'b0;
  logic        zero_next  = 1'b0;
  logic [31:0] src1_m, src2_m, wb_data_m;
  logic [5:0]  funct_m;
  logic [4:0]  shamt_m, wb_addr_m;

  function automatic bit legal_word(input logic [31:0] w);
    return (w[31:26] == 6'd0) &&
           (w[5:0] == 6'b001001 || w[5:0] == 6'b001010 || w[5:0] == 6'b010010 || w[5:0] == 6'b100010);
  endfunction

  function automatic bit exp_ready(input int c);
    return (c >= ready_from) && !(trap_from >= 0 && c >= trap_from);
  endfunction

  function automatic bit exp_illegal(input int c);
`ifdef ALU_ILLEGAL_TRAP_EN
    return (trap_from >= 0) && (c >= trap_from);
`else
    return c == ill_cyc;
`endif
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    logic [31:0] w;
    logic [31:0] res;
    cyc++;
    if (!rst_n) begin
      checking   = 1'b1;
      ready_from = cyc;
      trap_from  = -1;
      ex_cyc     = -1;
      wb_cyc     = -1;
      ill_cyc    = -1;
      zero_at    = -1;
      zero_m     = 1'b0;
    end else begin
      if (cyc == zero_at) zero_m = zero_next;
      if (instr_valid && exp_ready(cyc - 1)) begin
        w = instr;
        if (legal_word(w)) begin
          src1_m     = regs[w[25:21]];
          src2_m     = regs[w[20:16]];
          funct_m    = w[5:0];
          shamt_m    = w[10:6];
          res        = alu_op(funct_m, src1_m, src2_m, shamt_m);
          ex_cyc     = cyc + 1;
          zero_next  = (res == 32'd0);
          zero_at    = cyc + 2;
          wb_cyc     = (w[15:11] != 5'd0) ? cyc + 2 : -1;
          wb_addr_m  = w[15:11];
          wb_data_m  = res;
          ready_from = cyc + 3;
        end else begin
          ill_cyc    = cyc;
          ready_from = cyc + 1;
`ifdef ALU_ILLEGAL_TRAP_EN
          trap_from  = cyc;
`endif
        end
      end
    end
  end

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_ready(cyc)});
      chk("wb_en", {31'd0, wb_en}, {31'd0, cyc == wb_cyc});
      if (cyc == wb_cyc) begin
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, wb_addr_m});
        chk("wb_data", wb_data, wb_data_m);
      end
      chk("illegal", {31'd0, illegal}, {31'd0, exp_illegal(cyc)});
      chk("zero_flag", {31'd0, zero_flag}, {31'd0, zero_m});
      if (cyc == ex_cyc) begin
        chk("alu_src1", alu_src1, src1_m);
        chk("alu_src2", alu_src2, src2_m);
        chk("alu_funct", {26'd0, alu_funct}, {26'd0, funct_m});
        chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, shamt_m});
      end
      chk("funct_in_set", {31'd0, (alu_funct == 6'd0) || legal_word({26'd0, alu_funct})}, 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic go(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Presents a word for one cycle from a falling edge; n is the edge it was offered at.
  task automatic issue(input logic [31:0] w, output int n);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  int n;

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0000_0000;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0000_0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_alu_src1", alu_src1, 32'd0);
    chk("rst_alu_funct", {26'd0, alu_funct}, 32'd0);
    chk("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // 1: add 5 + 7 into rd=3
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    issue(rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001), n);
    go(n + 1);
    chk("t1_funct", {26'd0, alu_funct}, 32'h0000_0009);
    chk("t1_wb_early", {31'd0, wb_en}, 32'd0);
    go(n + 2);
    chk("t1_wb_en", {31'd0, wb_en}, 32'd1);
    chk("t1_wb_addr", {27'd0, wb_addr}, 32'd3);
    chk("t1_wb_data", wb_data, 32'd12);
    chk("t1_zero", {31'd0, zero_flag}, 32'd0);
    go(n + 3);
    chk("t1_ready", {31'd0, instr_ready}, 32'd1);

    // 2: sub of equal operands into rd=4
    regs[5] = 32'h0000_1234;
    regs[6] = 32'h0000_1234;
    issue(rtype(6'd0, 5'd5, 5'd6, 5'd4, 5'd0, 6'b001010), n);
    go(n + 2);
    chk("t2_wb_data", wb_data, 32'd0);
    chk("t2_zero", {31'd0, zero_flag}, 32'd1);
    go(n + 3);

    // 3: srl by 4, then or
    regs[7] = 32'h8000_0000;
    issue(rtype(6'd0, 5'd7, 5'd0, 5'd8, 5'd4, 6'b100010), n);
    go(n + 2);
    chk("t3_srl", wb_data, 32'h0800_0000);
    go(n + 3);
    regs[9]  = 32'h0000_00F0;
    regs[10] = 32'h0000_000F;
    issue(rtype(6'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'b010010), n);
    go(n + 2);
    chk("t3_or", wb_data, 32'h0000_00FF);
    chk("t3_or_zero", {31'd0, zero_flag}, 32'd0);
    go(n + 3);

    // 4: add into rd=0 -- no write-back, zero flag still follows the result (0 + 0)
    issue(rtype(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'b001001), n);
    go(n + 2);
    chk("t4_no_wb", {31'd0, wb_en}, 32'd0);
    chk("t4_zero", {31'd0, zero_flag}, 32'd1);
    go(n + 3);
    chk("t4_ready", {31'd0, instr_ready}, 32'd1);

    // 6: reset during EXEC aborts, then a normal add
    issue(rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001), n);
    go(n + 1);
    rst_n = 1'b0;
    go(n + 2);
    chk("t6_no_wb", {31'd0, wb_en}, 32'd0);
    chk("t6_src1", alu_src1, 32'd0);
    chk("t6_funct", {26'd0, alu_funct}, 32'd0);
    chk("t6_wb_data", wb_data, 32'd0);
    chk("t6_ready", {31'd0, instr_ready}, 32'd1);
    rst_n = 1'b1;
    issue(rtype(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, 6'b001001), n);
    go(n + 2);
    chk("t6_after_wb", {31'd0, wb_en}, 32'd1);
    chk("t6_after_data", wb_data, 32'd12);
    go(n + 3);

    // 5: illegal words (funct 0, then op != 0)
    issue(rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000000), n);
    chk("t5_illegal", {31'd0, illegal}, 32'd1);
    chk("t5_busy", {31'd0, instr_ready}, 32'd0);
`ifdef ALU_ILLEGAL_TRAP_EN
    go(n + 3);
    chk("t5_trap_sticky", {31'd0, illegal}, 32'd1);
    chk("t5_trap_ready", {31'd0, instr_ready}, 32'd0);
    issue(rtype(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001), n);
    go(n + 3);
    chk("t5_trap_no_wb", {31'd0, wb_en}, 32'd0);
    chk("t5_trap_held", {31'd0, instr_ready}, 32'd0);
`else
    go(n + 1);
    chk("t5_pulse_end", {31'd0, illegal}, 32'd0);
    chk("t5_ready_back", {31'd0, instr_ready}, 32'd1);
    issue(rtype(6'b000010, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001), n);
    chk("t5_op_illegal", {31'd0, illegal}, 32'd1);
    go(n + 2);
    chk("t5_op_no_wb", {31'd0, wb_en}, 32'd0);
    chk("t5_op_ready", {31'd0, instr_ready}, 32'd1);
`endif

    // Recovery through reset, then one more add
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rec_illegal", {31'd0, illegal}, 32'd0);
    chk("rec_ready", {31'd0, instr_ready}, 32'd1);
    issue(rtype(6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'b001001), n);
    go(n + 2);
    chk("rec_wb_addr", {27'd0, wb_addr}, 32'd12);
    chk("rec_wb_data", wb_data, 32'd12);
    go(n + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
